// File: rtl/lane_traffic_controller.sv
// lane_traffic_controller: per-frame car X positions for the sprite datapath.
// Four lanes share one add/wrap unit, swept by a small FSM during vblank.
//
// Ports:
//   i_Clk, i_Reset       pixel clock, synchronous active-high reset
//   i_H_Counter/V        VGA sync counters; tick on H==0, V==V_VISIBLE_AREA
//   i_Restart            reload initial positions/counters, abort sweep
//   i_Pause              freeze motion (sampled at tick detection)
//   i_Speed              step size = i_Speed + 1 pixels
//   o_CarN_X_Position    lane X positions, 0 <= X < H_VISIBLE_AREA+TILE_SIZE
//   o_Reverse            per-lane direction (LANE_DIR)
//   o_Busy               high while the lane sweep runs
//   o_Frame_Tick         one-cycle pulse per frame
module lane_traffic_controller #(
  parameter int TILE_SIZE      = 32,
  parameter int H_VISIBLE_AREA = 640,
  parameter int V_VISIBLE_AREA = 480,
  parameter logic [3:0] LANE_DIR = 4'b0101,
  parameter int LANE0_PERIOD   = 2,
  parameter int LANE1_PERIOD   = 3,
  parameter int LANE2_PERIOD   = 1,
  parameter int LANE3_PERIOD   = 4,
  parameter int LANE0_INIT_X   = 0,
  parameter int LANE1_INIT_X   = 160,
  parameter int LANE2_INIT_X   = 320,
  parameter int LANE3_INIT_X   = 480
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [9:0] i_H_Counter,
  input  logic [9:0] i_V_Counter,
  input  logic       i_Restart,
  input  logic       i_Pause,
  input  logic [1:0] i_Speed,
  output logic [9:0] o_Car_1X_Position,
  output logic [9:0] o_Car_2X_Position,
  output logic [9:0] o_Car_3X_Position,
  output logic [9:0] o_Car_4X_Position,
  output logic [3:0] o_Reverse,
  output logic       o_Busy,
  output logic       o_Frame_Tick
);

  localparam logic [10:0] SPAN = 11'(H_VISIBLE_AREA + TILE_SIZE);

  typedef enum logic [2:0] {
    S_IDLE, S_LANE0, S_LANE1, S_LANE2, S_LANE3
  } state_t;

  // Period 0 behaves as period 1: step every frame.
  function automatic logic [3:0] lim(input int p);
    return (p <= 1) ? 4'd0 : 4'(p - 1);
  endfunction

  state_t      state_q, state_d;
  logic [9:0]  x_q [4];
  logic [3:0]  cnt_q [4];
  logic        tick_now, tick_q;

  logic        active;
  logic [1:0]  lane;
  logic [3:0]  lim_sel, cnt_sel, cnt_nx;
  logic        hit, right;
  logic [10:0] x_sel, step, addend, sum, nx;
  logic        unused_nx_msb;

  assign tick_now = (i_H_Counter == 10'd0) &&
                    (i_V_Counter == 10'(V_VISIBLE_AREA));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (tick_now && !i_Pause && !i_Restart)
                 state_d = S_LANE0;
      S_LANE0: state_d = S_LANE1;
      S_LANE1: state_d = S_LANE2;
      S_LANE2: state_d = S_LANE3;
      S_LANE3: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    active  = 1'b1;
    lane    = 2'd0;
    lim_sel = lim(LANE0_PERIOD);
    unique case (state_q)
      S_LANE0: begin lane = 2'd0; lim_sel = lim(LANE0_PERIOD); end
      S_LANE1: begin lane = 2'd1; lim_sel = lim(LANE1_PERIOD); end
      S_LANE2: begin lane = 2'd2; lim_sel = lim(LANE2_PERIOD); end
      S_LANE3: begin lane = 2'd3; lim_sel = lim(LANE3_PERIOD); end
      default: active = 1'b0;
    endcase
  end

  // Shared add/wrap unit. A left step that would underflow adds
  // (SPAN - step) instead, so one adder covers both directions.
  always_comb begin
    x_sel   = {1'b0, x_q[lane]};
    cnt_sel = cnt_q[lane];
    right   = LANE_DIR[lane];
    step    = {9'd0, i_Speed} + 11'd1;
    if (right)
      addend = step;
    else if (x_sel < step)
      addend = SPAN - step;
    else
      addend = ~step + 11'd1;
    sum = x_sel + addend;
    nx  = (right && sum >= SPAN) ? sum - SPAN : sum;
    hit    = cnt_sel >= lim_sel;
    cnt_nx = hit ? 4'd0 : cnt_sel + 4'd1;
  end

  assign unused_nx_msb = nx[10];

  always_ff @(posedge i_Clk) begin
    if (i_Reset || i_Restart) begin
      state_q  <= S_IDLE;
      x_q[0]   <= 10'(LANE0_INIT_X);
      x_q[1]   <= 10'(LANE1_INIT_X);
      x_q[2]   <= 10'(LANE2_INIT_X);
      x_q[3]   <= 10'(LANE3_INIT_X);
      cnt_q[0] <= 4'd0;
      cnt_q[1] <= 4'd0;
      cnt_q[2] <= 4'd0;
      cnt_q[3] <= 4'd0;
    end else begin
      state_q <= state_d;
      if (active) begin
        cnt_q[lane] <= cnt_nx;
        if (hit)
          x_q[lane] <= nx[9:0];
      end
    end
  end

  // The tick pulse tracks VGA timing only; pause/restart do not mask it.
  always_ff @(posedge i_Clk) begin
    if (i_Reset)
      tick_q <= 1'b0;
    else
      tick_q <= tick_now;
  end

  assign o_Car_1X_Position = x_q[0];
  assign o_Car_2X_Position = x_q[1];
  assign o_Car_3X_Position = x_q[2];
  assign o_Car_4X_Position = x_q[3];
  assign o_Reverse         = LANE_DIR;
  assign o_Busy            = active;
  assign o_Frame_Tick      = tick_q;

endmodule

// File: tb/tb_lane_traffic_controller.sv
// tb_lane_traffic_controller: randomized frames vs. a reference model,
// expected sweeps queued by the stimulus and checked by a monitor.
module tb_lane_traffic_controller;

  localparam int W = 672;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] H, V;
  logic       restart, pause;
  logic [1:0] speed;
  logic [9:0] c1, c2, c3, c4;
  logic [3:0] rev;
  logic       busy, ftick;

  always #5 clk = ~clk;

  lane_traffic_controller dut (
    .i_Clk(clk), .i_Reset(rst),
    .i_H_Counter(H), .i_V_Counter(V),
    .i_Restart(restart), .i_Pause(pause), .i_Speed(speed),
    .o_Car_1X_Position(c1), .o_Car_2X_Position(c2),
    .o_Car_3X_Position(c3), .o_Car_4X_Position(c4),
    .o_Reverse(rev), .o_Busy(busy), .o_Frame_Tick(ftick)
  );

  // kind: 0 normal sweep, 1 paused, 2 restart with tick, 3 aborted sweep
  typedef struct packed {
    logic [1:0]      kind;
    logic [3:0][9:0] pos;
  } rec_t;

  rec_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  int PER  [4] = '{2, 3, 1, 4};
  int INIT [4] = '{0, 160, 320, 480};
  bit RIGHT[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  int mx[4];
  int mc[4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] dpos(input int k);
    case (k)
      0: return c1;
      1: return c2;
      2: return c3;
      default: return c4;
    endcase
  endfunction

  function automatic int mv(input int x, input bit r, input int s);
    return r ? (x + s) % W : (x + W - s) % W;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mx[k] = INIT[k];
      mc[k] = 0;
    end
  endtask

  task automatic model_lane(input int k, input int s);
    if (mc[k] + 1 >= PER[k]) begin
      mc[k] = 0;
      mx[k] = mv(mx[k], RIGHT[k], s);
    end else begin
      mc[k]++;
    end
  endtask

  task automatic idle_inputs();
    int r;
    r = $urandom_range(0, 3);
    case (r)
      0: begin H = 10'd0; V = 10'd479; end
      1: begin H = 10'd1; V = 10'd480; end
      2: begin H = 10'd0; V = 10'd481; end
      default: begin
        H = 10'($urandom_range(1, 799));
        V = 10'($urandom_range(0, 524));
      end
    endcase
    pause = 1'($urandom_range(0, 1));
  endtask

  task automatic push_rec(input logic [1:0] kind);
    rec_t r;
    r.kind = kind;
    for (int k = 0; k < 4; k++) r.pos[k] = 10'(mx[k]);
    sbq.push_back(r);
  endtask

  task automatic frame(input bit pz, input bit rs, input logic [1:0] sp,
                       input int gap);
    @(posedge clk); #1;
    H = 10'd0; V = 10'd480;
    pause = pz; restart = rs; speed = sp;
    if (rs) begin
      model_reset();
      push_rec(2'd2);
    end else if (pz) begin
      push_rec(2'd1);
    end else begin
      for (int k = 0; k < 4; k++) model_lane(k, int'(sp) + 1);
      push_rec(2'd0);
    end
    @(posedge clk); #1;
    restart = 1'b0;
    idle_inputs();
    repeat (gap) begin
      @(posedge clk); #1;
      idle_inputs();
    end
  endtask

  // Monitor: every frame tick pops one expected sweep.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (ftick === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_tick", 1, 0);
        end else begin
          r = sbq.pop_front();
          chk("busy_t1", busy, (r.kind == 2'd0 || r.kind == 2'd3));
          chk("reverse", rev, 4'b0101);
          if (r.kind == 2'd3) begin
            @(negedge clk);
            chk("abort_lane0", c1, r.pos[0]);
          end else begin
            for (int j = 0; j < 4; j++) begin
              @(negedge clk);
              if (j == 0) chk("tick_width", ftick, 0);
              chk($sformatf("lane%0d_x", j), dpos(j), r.pos[j]);
              chk($sformatf("busy_t%0d", j + 2), busy,
                  (j < 3 && r.kind == 2'd0));
            end
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; restart = 1'b0; pause = 1'b0; speed = 2'd0;
    H = 10'd5; V = 10'd5;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++)
      chk($sformatf("reset_lane%0d", k), dpos(k), INIT[k]);
    chk("reset_busy", busy, 0);
    chk("reset_tick", ftick, 0);
    chk("reset_reverse", rev, 4'b0101);

    // First frame at speed 0: only lane 2 moves, 320 -> 321.
    frame(1'b0, 1'b0, 2'd0, 6);

    // Standalone restart, then 12 frames at speed 3.
    @(posedge clk); #1 restart = 1'b1;
    @(posedge clk); #1 restart = 1'b0;
    model_reset();
    @(negedge clk);
    chk("restart_lane2", c3, 320);
    for (int i = 0; i < 12; i++) frame(1'b0, 1'b0, 2'd3, 6);
    chk("run12_lane0", c1, 24);
    chk("run12_lane1", c2, 144);
    chk("run12_lane2", c3, 368);
    chk("run12_lane3", c4, 468);

    // Paused frames: ticks still pulse, nothing moves.
    for (int i = 0; i < 5; i++) frame(1'b1, 1'b0, 2'd3, 6);
    frame(1'b0, 1'b0, 2'd1, 6);

    // Restart at T+2 aborts the sweep after lane 0.
    @(posedge clk); #1;
    H = 10'd0; V = 10'd480; pause = 1'b0; speed = 2'd2;
    model_lane(0, 3);
    push_rec(2'd3);
    @(posedge clk); #1 idle_inputs();
    @(posedge clk); #1 restart = 1'b1;
    @(posedge clk); #1 restart = 1'b0;
    model_reset();
    @(negedge clk);
    for (int k = 0; k < 4; k++)
      chk($sformatf("abort_init%0d", k), dpos(k), INIT[k]);
    chk("abort_busy", busy, 0);
    repeat (6) begin @(posedge clk); #1 idle_inputs(); end

    // Randomized frames; long enough for lanes to wrap.
    for (int i = 0; i < 500; i++)
      frame(($urandom_range(0, 4) == 0), ($urandom_range(0, 49) == 0),
            2'($urandom_range(0, 3)), $urandom_range(5, 9));

    // Reset, restart and tick together: reset state, no tick pulse.
    @(posedge clk); #1;
    rst = 1'b1; restart = 1'b1; pause = 1'b0;
    H = 10'd0; V = 10'd480;
    @(posedge clk); #1;
    rst = 1'b0; restart = 1'b0; H = 10'd5; V = 10'd5;
    model_reset();
    @(negedge clk);
    chk("rst_rs_tick", ftick, 0);
    chk("rst_rs_busy", busy, 0);
    repeat (5) @(negedge clk);
    for (int k = 0; k < 4; k++)
      chk($sformatf("rst_rs_lane%0d", k), dpos(k), INIT[k]);
    chk("rst_rs_busy_late", busy, 0);

    repeat (10) @(posedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
